mole_scheduler: RTL
===================

Name: mole_scheduler

Overview:
- Per-hole mole lifecycle controller for the whack-a-mole game.
- Takes the spawn-rate tick and the pseudo-random value from the generator path, and schedules which holes show a mole.
- Times each mole's onscreen lifetime and resolves player whacks.
- Emits single-cycle hit/miss/escape pulses to the score keeper and visibility masks to the display path. Active only while the game FSM is in INGAME.

Parameters:
- NUM_HOLES, 5, number of holes; fixed at 5 by the 3-bit hole encoding.
- LIFETIME_TICKS, 8, ticks a mole stays UP before escaping (1..15).
- FLASH_TICKS, 2, ticks a HIT or ESCAPED hole is held before returning to OFF (1..15).
- MAX_ACTIVE, 3, maximum simultaneous UP moles (1..5).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on posedge clock)
- enable  in  1  high while game FSM is INGAME; low = synchronous clear
- tick  in  1  one-cycle spawn/lifetime pulse from rate divider
- rngValue  in  3  pseudo-random value, sampled only when tick=1
- hitIn  in  3  player input: 0 = none, 1..5 = hole, 6/7 = invalid
- molesVisible  out  5  bit i = hole i+1 is UP
- hitMask  out  5  bit i = hole i+1 is in HIT (display flash)
- activeCount  out  3  number of holes in UP
- hitPulse  out  1  one cycle: a whack landed on an UP mole
- hitHole  out  3  hole of last successful hit, valid with hitPulse, else 0
- missPulse  out  1  one cycle: a whack landed on a non-UP hole
- escapePulse  out  1  one cycle: one or more moles timed out

Behaviour:
- Per-hole state (2 bits): OFF=0, UP=1, HIT=2, ESCAPED=3. Each hole has a 4-bit timer.
- Reset (reset=0) or enable=0 does all of the following on the same edge; reset wins over everything:
  - every hole goes OFF with timer 0;
  - all outputs go to 0;
  - the previous-hit register is cleared.
- Press detection:
  - A press is hitIn in 1..5 and hitIn != prevHit, where prevHit is a register updated every cycle.
  - Holding the same value yields one press. Changing directly from one hole to another yields a new press.
  - hitIn 6/7 is ignored and not recorded as a press.
- On a press for hole h:
  - If h is UP: h goes to HIT, timer = FLASH_TICKS, hitPulse=1, hitHole=h.
  - Otherwise (OFF, HIT or ESCAPED): missPulse=1, and h's state is unchanged.
- On tick, with enable=1, each hole updates from its registered state at the start of the cycle:
  - UP with timer>1: decrement.
  - UP with timer==1: goes to ESCAPED, timer = FLASH_TICKS, escapePulse=1. Multiple escapes on the same tick give a single pulse.
  - HIT or ESCAPED with timer>1: decrement. With timer==1: goes OFF.
- Spawn on tick, with enable=1:
  - rngValue 0..4 selects hole rngValue+1; values 5..7 mean no spawn.
  - The selected hole spawns only if its registered state is OFF and registered activeCount < MAX_ACTIVE.
  - Spawn sets UP, timer = LIFETIME_TICKS.
  - A rejected spawn is dropped, never retried.
  - A hole leaving HIT/ESCAPED on this tick is not spawnable until the next tick.
- Simultaneous events:
  - Press on h in the same cycle as h's UP expiry: the hit wins. Result is HIT, hitPulse=1, no escape for h.
  - Press on h in the same cycle as a spawn into h: miss is reported (h was OFF), and the spawn still occurs.
  - Press and tick on different holes: both are processed independently in the same cycle.
- Latency:
  - All pulses and masks are registered and appear one cycle after the causing edge.
  - Pulses are exactly one cycle wide.
  - hitHole returns to 0 when hitPulse is 0.
- activeCount is registered, equal to the popcount of UP states, and never exceeds MAX_ACTIVE.

Decomposition:
- Shared package (mole_pkg):
  - hole-state encodings OFF/UP/HIT/ESCAPED;
  - HOLE_NONE=3'd0;
  - NUM_HOLES constant;
  - hole-index-to-one-hot function.
- Sub-module mole_slot, instantiated NUM_HOLES times:
  - holds one hole's state and timer;
  - inputs: tick, spawnReq, whackReq, clear;
  - outputs: state, expireEvt, hitEvt, missEvt.
- The top level handles press detection, spawn arbitration (MAX_ACTIVE check), pulse OR-reduction, activeCount and hitHole.

Test Plan:
1. reset=0 for 2 cycles with tick=1, hitIn=3, rngValue=0 -> all outputs 0; molesVisible=00000, activeCount=0.
2. enable=1; tick with rngValue=2 -> next cycle molesVisible=00100, activeCount=1; rngValue=6 on the next tick -> no change.
3. Hole 3 UP; hitIn=3 held 10 cycles -> exactly one hitPulse, with hitHole=3, molesVisible=00000, hitMask=00100; after 2 ticks hitMask=00000 and hole 3 is spawnable again.
4. Spawn hole 1 (rngValue=0), no press, 8 ticks -> escapePulse=1 after the 8th tick, bit 0 cleared; spawn into hole 1 on the next tick is rejected, on the third tick accepted.
5. Ticks with rngValue=0,1,2,3 -> molesVisible=00111, activeCount=3, hole 4 not spawned; hitIn=5 press -> missPulse=1, no state change.
6. Press on hole 2 in the same cycle as its 8th tick -> hitPulse=1, escapePulse=0, hitMask=00010; enable dropped mid-game -> next cycle all masks 0, activeCount=0.

Source files
------------

// File: rtl/mole_pkg.sv
// Shared definitions for the whack-a-mole hole scheduler: hole-state encodings,
// hole count and a 1-based hole-number to one-hot helper.
package mole_pkg;

    localparam int         NUM_HOLES = 5;
    localparam logic [2:0] HOLE_NONE = 3'd0;

    typedef enum logic [1:0] {
        HOLE_OFF     = 2'd0,
        HOLE_UP      = 2'd1,
        HOLE_HIT     = 2'd2,
        HOLE_ESCAPED = 2'd3
    } hole_state_t;

    // Hole numbers are 1-based; 0 and out-of-range values map to an empty mask.
    function automatic logic [NUM_HOLES-1:0] hole_onehot(input logic [2:0] hole);
        logic [NUM_HOLES-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_HOLES; i++) begin
            if (hole == 3'(i + 1)) oh[i] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/mole_slot.sv
// One hole's lifecycle: spawn, lifetime countdown, whack resolution and flash hold.
//   state        | meaning
//   HOLE_OFF     | empty, may accept a spawn on a tick
//   HOLE_UP      | mole showing, timer counts remaining lifetime ticks
//   HOLE_HIT     | whacked, timer counts remaining flash ticks
//   HOLE_ESCAPED | timed out, timer counts remaining flash ticks
module mole_slot
    import mole_pkg::*;
#(
    parameter int LIFETIME_TICKS = 8,
    parameter int FLASH_TICKS    = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       tick,
    input  logic       spawn_req,
    input  logic       whack_req,
    output logic [1:0] state,
    output logic       expire_evt,
    output logic       hit_evt,
    output logic       miss_evt
);

    localparam logic [3:0] LIFE_C  = 4'(LIFETIME_TICKS);
    localparam logic [3:0] FLASH_C = 4'(FLASH_TICKS);

    hole_state_t state_q, state_d;
    logic [3:0]  timer_q, timer_d;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        expire_evt = 1'b0;
        hit_evt    = 1'b0;
        miss_evt   = whack_req && (state_q != HOLE_UP);
        // A whack on an UP mole beats any same-cycle expiry of that mole.
        if (whack_req && state_q == HOLE_UP) begin
            state_d = HOLE_HIT;
            timer_d = FLASH_C;
            hit_evt = 1'b1;
        end else if (tick) begin
            case (state_q)
                HOLE_OFF: begin
                    if (spawn_req) begin
                        state_d = HOLE_UP;
                        timer_d = LIFE_C;
                    end
                end
                HOLE_UP: begin
                    if (timer_q > 4'd1) begin
                        timer_d = timer_q - 4'd1;
                    end else begin
                        state_d    = HOLE_ESCAPED;
                        timer_d    = FLASH_C;
                        expire_evt = 1'b1;
                    end
                end
                default: begin
                    if (timer_q > 4'd1) begin
                        timer_d = timer_q - 4'd1;
                    end else begin
                        state_d = HOLE_OFF;
                        timer_d = 4'd0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            state_q <= HOLE_OFF;
            timer_q <= 4'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole scheduler: press detection, spawn arbitration against the active
// limit, and registered pulse/mask outputs over a bank of hole slots.
module mole_scheduler
    import mole_pkg::*;
#(
    parameter int LIFETIME_TICKS = 8,
    parameter int FLASH_TICKS    = 2,
    parameter int MAX_ACTIVE     = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       tick,
    input  logic [2:0] rngValue,
    input  logic [2:0] hitIn,
    output logic [4:0] molesVisible,
    output logic [4:0] hitMask,
    output logic [2:0] activeCount,
    output logic       hitPulse,
    output logic [2:0] hitHole,
    output logic       missPulse,
    output logic       escapePulse
);

    localparam logic [2:0] MAX_ACTIVE_C = 3'(MAX_ACTIVE);

    logic [2:0] prev_hit_q, prev_hit_d;
    logic [2:0] active_q, active_d;
    logic       hit_pulse_q, hit_pulse_d;
    logic [2:0] hit_hole_q, hit_hole_d;
    logic       miss_pulse_q, miss_pulse_d;
    logic       escape_pulse_q, escape_pulse_d;

    logic                 press;
    logic [NUM_HOLES-1:0] whack_req, spawn_req;
    logic [NUM_HOLES-1:0] up_mask, hit_mask, off_mask;
    logic [NUM_HOLES-1:0] expire_evt, hit_evt, miss_evt;
    logic [1:0]           slot_state [NUM_HOLES];

    function automatic logic [2:0] count_ones(input logic [NUM_HOLES-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < NUM_HOLES; i++) n = n + {2'b00, v[i]};
        return n;
    endfunction

    always_comb begin
        prev_hit_d = hitIn;
        press      = (hitIn != HOLE_NONE) && (hitIn <= 3'(NUM_HOLES)) && (hitIn != prev_hit_q);
        whack_req  = press ? hole_onehot(hitIn) : '0;
        spawn_req  = '0;
        if (tick && (rngValue < 3'(NUM_HOLES)) && (active_q < MAX_ACTIVE_C)) begin
            spawn_req = hole_onehot(rngValue + 3'd1);
        end
        hit_pulse_d    = |hit_evt;
        hit_hole_d     = hit_pulse_d ? hitIn : HOLE_NONE;
        miss_pulse_d   = |miss_evt;
        escape_pulse_d = |expire_evt;
        // Only an OFF hole accepts a spawn, so the accepted spawn is the masked request.
        active_d = active_q + count_ones(spawn_req & off_mask)
                 - count_ones(hit_evt) - count_ones(expire_evt);
    end

    for (genvar g = 0; g < NUM_HOLES; g++) begin : g_slot
        mole_slot #(
            .LIFETIME_TICKS(LIFETIME_TICKS),
            .FLASH_TICKS   (FLASH_TICKS)
        ) u_slot (
            .clock     (clock),
            .reset     (reset),
            .clear     (!enable),
            .tick      (tick),
            .spawn_req (spawn_req[g]),
            .whack_req (whack_req[g]),
            .state     (slot_state[g]),
            .expire_evt(expire_evt[g]),
            .hit_evt   (hit_evt[g]),
            .miss_evt  (miss_evt[g])
        );
        assign up_mask[g]  = (slot_state[g] == HOLE_UP);
        assign hit_mask[g] = (slot_state[g] == HOLE_HIT);
        assign off_mask[g] = (slot_state[g] == HOLE_OFF);
    end

    always_ff @(posedge clock) begin
        if (!reset || !enable) begin
            prev_hit_q     <= HOLE_NONE;
            active_q       <= 3'd0;
            hit_pulse_q    <= 1'b0;
            hit_hole_q     <= HOLE_NONE;
            miss_pulse_q   <= 1'b0;
            escape_pulse_q <= 1'b0;
        end else begin
            prev_hit_q     <= prev_hit_d;
            active_q       <= active_d;
            hit_pulse_q    <= hit_pulse_d;
            hit_hole_q     <= hit_hole_d;
            miss_pulse_q   <= miss_pulse_d;
            escape_pulse_q <= escape_pulse_d;
        end
    end

    assign molesVisible = up_mask;
    assign hitMask      = hit_mask;
    assign activeCount  = active_q;
    assign hitPulse     = hit_pulse_q;
    assign hitHole      = hit_hole_q;
    assign missPulse    = miss_pulse_q;
    assign escapePulse  = escape_pulse_q;

endmodule
